// File: rtl/wb_sram_bridge.sv
// Wishbone B4 classic slave to OpenRAM port 0; write ack 2 cycles, read ack 3 cycles after strobe, no wait-state backpressure beyond that.
// Optional `WBSRAM_WRITE_PROTECT_EN adds wp_i, which silently discards (but still acks) writes.
module wb_sram_bridge #(
  parameter logic [31:0] BASE_ADDR        = 32'h3000_0000,
  parameter int          ADDR_WIDTH_WORDS = 9
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [31:0]                 wbs_adr_i,
  input  logic [31:0]                 wbs_dat_i,
`ifdef WBSRAM_WRITE_PROTECT_EN
  input  logic                        wp_i,
`endif
  output logic                        wbs_ack_o,
  output logic [31:0]                 wbs_dat_o,
  output logic                        sram_clk0,
  output logic                        sram_csb0,
  output logic                        sram_web0,
  output logic [3:0]                  sram_wmask0,
  output logic [ADDR_WIDTH_WORDS-1:0] sram_addr0,
  output logic [31:0]                 sram_din0,
  input  logic [31:0]                 sram_dout0
);

  localparam int LSB = ADDR_WIDTH_WORDS + 2;

  typedef enum logic [1:0] {IDLE, MEM, RDATA, ACK} state_t;

  state_t                      r_state;
  logic                        r_csb;
  logic                        r_web;
  logic [3:0]                  r_wmask;
  logic [ADDR_WIDTH_WORDS-1:0] r_addr;
  logic [31:0]                 r_din;
  logic                        r_ack;
  logic [31:0]                 r_dat;

  logic w_hit;
  logic w_wp_block;

  assign w_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:LSB] == BASE_ADDR[31:LSB]);

`ifdef WBSRAM_WRITE_PROTECT_EN
  assign w_wp_block = wbs_we_i & wp_i;
`else
  assign w_wp_block = 1'b0;
`endif

  // Every macro pin comes straight from a flop; the Wishbone inputs only reach the SRAM through registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_wmask <= 4'b0000;
      r_addr  <= '0;
      r_din   <= 32'h0;
      r_ack   <= 1'b0;
      r_dat   <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_csb   <= w_wp_block;
            r_web   <= ~wbs_we_i;
            r_addr  <= wbs_adr_i[LSB-1:2];
            r_din   <= wbs_dat_i;
            r_wmask <= wbs_we_i ? wbs_sel_i : 4'b0000;
            r_state <= MEM;
          end
        end
        MEM: begin
          r_csb <= 1'b1;
          r_web <= 1'b1;
          if (!r_web) begin
            r_ack   <= 1'b1;
            r_state <= ACK;
          end else begin
            r_state <= RDATA;
          end
        end
        RDATA: begin
          r_dat   <= sram_dout0;
          r_ack   <= 1'b1;
          r_state <= ACK;
        end
        ACK: begin
          // Bus deliberately not sampled here so a held strobe cannot re-issue.
          r_ack   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sram_clk0   = wb_clk_i;
  assign sram_csb0   = r_csb;
  assign sram_web0   = r_web;
  assign sram_wmask0 = r_wmask;
  assign sram_addr0  = r_addr;
  assign sram_din0   = r_din;
  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed bench for wb_sram_bridge with a behavioural 32x512 SRAM on port 0.
module tb_wb_sram_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic        sclk, csb, web;
  logic [3:0]  wmask;
  logic [8:0]  saddr;
  logic [31:0] sdin;
  logic [31:0] sdout;
`ifdef WBSRAM_WRITE_PROTECT_EN
  logic        wp;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:511];

  int          ack_at, ack_cnt, csb_cnt;
  logic [31:0] rd_val, cap_din;
  logic [8:0]  cap_addr;
  logic        cap_web;
  logic [3:0]  cap_wmask;

  always #5 clk = ~clk;

  wb_sram_bridge dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat_i),
`ifdef WBSRAM_WRITE_PROTECT_EN
    .wp_i       (wp),
`endif
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_o),
    .sram_clk0  (sclk),
    .sram_csb0  (csb),
    .sram_web0  (web),
    .sram_wmask0(wmask),
    .sram_addr0 (saddr),
    .sram_din0  (sdin),
    .sram_dout0 (sdout)
  );

  // Behavioural OpenRAM port: command captured at the edge, read data valid the following cycle.
  always @(posedge sclk) begin
    if (!csb) begin
      if (!web) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) mem[saddr][8*b +: 8] <= sdin[8*b +: 8];
      end else begin
        sdout <= mem[saddr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge, then watch ncyc negedges; strobe drops on ack or at drop_at.
  task automatic bus_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int ncyc, input int drop_at);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    ack_at = -1; ack_cnt = 0; csb_cnt = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (csb === 1'b0) begin
        csb_cnt++;
        cap_addr = saddr; cap_web = web; cap_wmask = wmask; cap_din = sdin;
      end
      if (ack === 1'b1) begin
        ack_cnt++;
        if (ack_at < 0) ack_at = c;
        rd_val = dat_o;
      end
      if (ack === 1'b1 || c == drop_at) begin
        cyc = 1'b0; stb = 1'b0;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    sdout = 32'h0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_i = 32'h0;
`ifdef WBSRAM_WRITE_PROTECT_EN
    wp = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_csb", {31'b0, csb}, 32'd1);
    chk("rst_web", {31'b0, web}, 32'd1);
    chk("rst_wmask", {28'b0, wmask}, 32'h0);
    chk("rst_addr", {23'b0, saddr}, 32'h0);
    chk("rst_din", sdin, 32'h0);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_dat", dat_o, 32'h0);
    rst = 1'b0;

    // Full-word write
    bus_op(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 6, 0);
    chk("wr_csb_pulses", csb_cnt, 1);
    chk("wr_addr", {23'b0, cap_addr}, 32'd4);
    chk("wr_web", {31'b0, cap_web}, 32'd0);
    chk("wr_wmask", {28'b0, cap_wmask}, 32'hF);
    chk("wr_din", cap_din, 32'hDEAD_BEEF);
    chk("wr_ack_lat", ack_at, 2);
    chk("wr_ack_cnt", ack_cnt, 1);
    chk("wr_dat_hold", dat_o, 32'h0);

    // Read back
    bus_op(1'b0, 32'h3000_0010, 32'h0, 4'hF, 6, 0);
    chk("rd_csb_pulses", csb_cnt, 1);
    chk("rd_web", {31'b0, cap_web}, 32'd1);
    chk("rd_wmask", {28'b0, cap_wmask}, 32'h0);
    chk("rd_ack_lat", ack_at, 3);
    chk("rd_ack_cnt", ack_cnt, 1);
    chk("rd_data", rd_val, 32'hDEAD_BEEF);

    // Byte write into lane 1, low address bits ignored
    bus_op(1'b1, 32'h3000_0013, 32'h0000_AB00, 4'b0010, 6, 0);
    chk("bw_wmask", {28'b0, cap_wmask}, 32'h2);
    chk("bw_addr", {23'b0, cap_addr}, 32'd4);
    bus_op(1'b0, 32'h3000_0010, 32'h0, 4'hF, 6, 0);
    chk("bw_rd_data", rd_val, 32'hDEAD_ABEF);

    // Out-of-window requests
    bus_op(1'b1, 32'h3000_0800, 32'h1111_1111, 4'hF, 10, 0);
    chk("miss_hi_csb", csb_cnt, 0);
    chk("miss_hi_ack", ack_cnt, 0);
    bus_op(1'b0, 32'h2FFF_FFFC, 32'h0, 4'hF, 10, 0);
    chk("miss_lo_csb", csb_cnt, 0);
    chk("miss_lo_ack", ack_cnt, 0);

    // Strobe abandoned after one cycle still completes with one ack
    bus_op(1'b0, 32'h3000_07FC, 32'h0, 4'hF, 8, 1);
    chk("drop_ack_cnt", ack_cnt, 1);
    chk("drop_ack_lat", ack_at, 3);
    chk("drop_addr", {23'b0, cap_addr}, 32'd511);

    // Restore a non-zero read value before the reset test
    bus_op(1'b0, 32'h3000_0010, 32'h0, 4'hF, 6, 0);
    chk("pre_rst_data", dat_o, 32'hDEAD_ABEF);

    // Reset in the MEM cycle of a read
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010; sel = 4'hF;
    @(negedge clk);
    chk("mid_csb_low", {31'b0, csb}, 32'd0);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("mid_rst_ack", {31'b0, ack}, 32'd0);
    chk("mid_rst_csb", {31'b0, csb}, 32'd1);
    chk("mid_rst_dat", dat_o, 32'h0);
    chk("mid_rst_addr", {23'b0, saddr}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_ack", {31'b0, ack}, 32'd0);
    bus_op(1'b0, 32'h3000_0010, 32'h0, 4'hF, 6, 0);
    chk("post_rst_lat", ack_at, 3);
    chk("post_rst_data", rd_val, 32'hDEAD_ABEF);

`ifdef WBSRAM_WRITE_PROTECT_EN
    bus_op(1'b1, 32'h3000_0000, 32'hCAFE_0001, 4'hF, 6, 0);
    wp = 1'b1;
    bus_op(1'b1, 32'h3000_0000, 32'h1234_5678, 4'hF, 6, 0);
    chk("wp_csb_pulses", csb_cnt, 0);
    chk("wp_ack_lat", ack_at, 2);
    chk("wp_ack_cnt", ack_cnt, 1);
    bus_op(1'b0, 32'h3000_0000, 32'h0, 4'hF, 6, 0);
    chk("wp_rd_csb", csb_cnt, 1);
    chk("wp_rd_data", rd_val, 32'hCAFE_0001);
    wp = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_sram_bridge.md
Name: wb_sram_bridge

Overview:
- Wishbone B4 classic slave that bridges the Caravel management Wishbone bus to port 0 of a sky130 OpenRAM macro (32-bit x 512-word class).
- Sits between the management SoC Wishbone interconnect and the IRAM/DRAM macro.
- Lets firmware load and inspect instruction/data memory before and during core operation.
- Registers every SRAM control signal, so no combinational path runs from the Wishbone inputs to the macro pins.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte base address of the decode window; must be aligned to the window size.
- ADDR_WIDTH_WORDS, 9, SRAM word-address width. Window size is 4*2^ADDR_WIDTH_WORDS bytes.

Ports:
- wb_clk_i  input  1  sole clock; also drives sram_clk0.
- wb_rst_i  input  1  synchronous reset, active-high.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_we_i  input  1  1 = write.
- wbs_sel_i  input  4  byte selects.
- wbs_adr_i  input  32  byte address.
- wbs_dat_i  input  32  write data.
- wbs_ack_o  output  1  one-cycle acknowledge.
- wbs_dat_o  output  32  read data (registered).
- sram_clk0  output  1  equals wb_clk_i.
- sram_csb0  output  1  chip select, active-low.
- sram_web0  output  1  write enable, active-low.
- sram_wmask0  output  4  byte write mask.
- sram_addr0  output  ADDR_WIDTH_WORDS  word address.
- sram_din0  output  32  SRAM write data.
- sram_dout0  input  32  SRAM read data; valid in the cycle after the command edge.

Behaviour:
- Clocking and reset:
  - One clock domain, wb_clk_i.
  - Reset is synchronous and active-high on wb_rst_i.
- Address decode:
  - hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:ADDR_WIDTH_WORDS+2] == BASE_ADDR[31:ADDR_WIDTH_WORDS+2]).
  - wbs_adr_i[1:0] are ignored.
  - sram_addr0 is loaded from wbs_adr_i[ADDR_WIDTH_WORDS+1:2].
  - A non-hit request is ignored: no SRAM access, no ack.
- Reset values: state IDLE, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, wbs_ack_o=0, wbs_dat_o=0.
- FSM states: IDLE, MEM, RDATA, ACK.
- IDLE:
  - On hit at edge E0, register csb0=0, web0=~wbs_we_i, addr, din=wbs_dat_i, wmask=(we ? wbs_sel_i : 4'b0000); go to MEM.
- MEM (the SRAM captures the command at edge E1):
  - At E1 set csb0=1 and web0=1.
  - Write: set ack=1 and go to ACK.
  - Read: go to RDATA.
- RDATA:
  - At E2 set wbs_dat_o=sram_dout0 and ack=1; go to ACK.
- ACK:
  - At the next edge set ack=0 and go to IDLE unconditionally.
  - The bus is not sampled in ACK, so a held strobe is never double-issued.
- Latency:
  - Write: ack is visible 2 cycles after the strobe is first sampled.
  - Read: ack is visible 3 cycles after the strobe is first sampled.
  - Minimum back-to-back period: 3 cycles for writes, 4 cycles for reads.
- wbs_dat_o holds the last read value. It changes only in RDATA or on reset.
- csb0 is low for exactly one cycle per accepted access.
- If cyc/stb drop mid-transaction, the access still completes and ack still pulses once.
- Reset mid-operation: at the next edge all outputs return to their reset values and the state returns to IDLE. A command already captured by the SRAM is not reverted.

Optional Feature:
- Macro: WBSRAM_WRITE_PROTECT_EN.
- Defined:
  - Adds input port wp_i (1 bit).
  - A write sampled in IDLE while wp_i=1 keeps csb0=1 (no SRAM access).
  - The FSM still passes MEM -> ACK with normal write timing, so the write is acked but discarded.
  - Reads are unaffected.
- Undefined: wp_i does not exist and all hit writes reach the SRAM.

Test Plan:
- Write 0xDEADBEEF to 0x3000_0010, sel=4'hF -> single csb0 low pulse with addr0=4, web0=0, wmask0=4'hF, din0=0xDEADBEEF; ack high exactly one cycle, 2 cycles after the strobe.
- Read 0x3000_0010 (behavioural SRAM model) -> csb0 pulse with web0=1 and wmask0=0; ack 3 cycles after the strobe with wbs_dat_o=0xDEADBEEF.
- Byte write sel=4'b0010 data=0x0000AB00, then read -> 0xDEADABEF.
- Access 0x3000_0800 and 0x2FFF_FFFC with defaults -> no csb0 pulse and no ack over 10 cycles; state stays IDLE.
- Assert wb_rst_i in the MEM cycle of a read -> next cycle ack=0, csb0=1, wbs_dat_o=0; a new read afterwards completes normally.
- With WBSRAM_WRITE_PROTECT_EN: wp_i=1, write 0x12345678 to 0x3000_0000 -> ack at 2 cycles with no csb0 pulse; readback returns the prior contents.
